// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Shares one SPI master TX/RX FIFO pair between two requesters. Granted
//   requests are packed into 41-bit frames {wr, cs, addr, data} and written to
//   the TX FIFO. Every granted read leaves its port number in a small tag
//   FIFO, so each RX word is routed back to the port that issued the oldest
//   outstanding read.
//
//   Ports
//     SCLK, SRESET            clock, asynchronous active-high reset
//     reqN_*                  request from port N (valid/wr/cs/addr/wdata);
//                             reqN_ready pulses for one cycle on accept
//     rspN_valid/rspN_rdata   one-cycle read response to port N
//     tx_wr_en/tx_data/tx_full   TX FIFO write side
//     rx_rd_en/rx_data/rx_empty  RX FIFO read side (data one cycle after rd_en)
//     rd_outstanding          reads issued and not yet returned
//     err_orphan              sticky: RX word arrived with no read outstanding
//
//   Response FSM
//     state  | meaning
//     R_IDLE | waiting for an RX word; issues rx_rd_en when one is present
//     R_CAP  | rx_data is valid this cycle; route it to the head tag or drop it
module spi_txn_arbiter #(
  parameter int TAG_DEPTH = 4,
  parameter int TAG_AW    = 2
) (
  input  logic              SCLK,
  input  logic              SRESET,
  input  logic              req0_valid,
  input  logic              req0_wr,
  input  logic              req0_cs,
  input  logic [6:0]        req0_addr,
  input  logic [31:0]       req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_wr,
  input  logic              req1_cs,
  input  logic [6:0]        req1_addr,
  input  logic [31:0]       req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              tx_wr_en,
  output logic [40:0]       tx_data,
  input  logic              tx_full,
  output logic              rx_rd_en,
  input  logic [31:0]       rx_data,
  input  logic              rx_empty,
  output logic [TAG_AW:0]   rd_outstanding,
  output logic              err_orphan
);

  localparam logic [TAG_AW:0]   CNT_FULL = (TAG_AW+1)'(TAG_DEPTH);
  localparam logic [TAG_AW:0]   CNT_ONE  = (TAG_AW+1)'(1);
  localparam logic [TAG_AW-1:0] PTR_ONE  = TAG_AW'(1);

  typedef enum logic {R_IDLE, R_CAP} rsp_state_t;

  rsp_state_t            state, state_nxt;
  logic                  rr;
  logic [TAG_DEPTH-1:0]  tag_mem;
  logic [TAG_AW-1:0]     wr_ptr, rd_ptr;
  logic [TAG_AW:0]       tag_count;
  logic                  tags_full, elig0, elig1, grant0, grant1;
  logic                  push, pop, orphan, pop_tag;
  logic [40:0]           frame;

  // A port whose ready is high this cycle is masked so a request that is
  // still held (requester has not yet seen ready) is not accepted twice.
  always_comb begin
    tags_full = (tag_count == CNT_FULL);
    elig0     = req0_valid && !req0_ready && (req0_wr || !tags_full);
    elig1     = req1_valid && !req1_ready && (req1_wr || !tags_full);
    grant0    = !tx_full && elig0 && (!elig1 || !rr);
    grant1    = !tx_full && elig1 && (!elig0 || rr);
    push      = (grant0 && !req0_wr) || (grant1 && !req1_wr);
    if (grant1)
      frame = {req1_wr, req1_cs, req1_addr, req1_wr ? req1_wdata : 32'h0};
    else
      frame = {req0_wr, req0_cs, req0_addr, req0_wr ? req0_wdata : 32'h0};
  end

  assign pop_tag        = tag_mem[rd_ptr];
  assign rd_outstanding = tag_count;

  // rx_rd_en is combinational so the FIFO data lands exactly in R_CAP.
  // It is held low during reset so no word is consumed while SRESET is high.
  always_comb begin
    state_nxt = state;
    rx_rd_en  = 1'b0;
    pop       = 1'b0;
    orphan    = 1'b0;
    case (state)
      R_IDLE: begin
        if (!rx_empty && !SRESET) begin
          rx_rd_en  = 1'b1;
          state_nxt = R_CAP;
        end
      end
      R_CAP: begin
        state_nxt = R_IDLE;
        if (tag_count != '0) pop    = 1'b1;
        else                 orphan = 1'b1;
      end
    endcase
  end

  always_ff @(posedge SCLK or posedge SRESET) begin
    if (SRESET) state <= R_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge SCLK or posedge SRESET) begin
    if (SRESET) begin
      rr         <= 1'b0;
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_count  <= '0;
      tx_wr_en   <= 1'b0;
      tx_data    <= '0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
      err_orphan <= 1'b0;
    end else begin
      tx_wr_en   <= grant0 || grant1;
      req0_ready <= grant0;
      req1_ready <= grant1;
      if (grant0 || grant1) tx_data <= frame;
      if (grant0)      rr <= 1'b1;
      else if (grant1) rr <= 1'b0;

      if (push) begin
        tag_mem[wr_ptr] <= grant1;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   tag_count <= tag_count + CNT_ONE;
        2'b01:   tag_count <= tag_count - CNT_ONE;
        default: ;
      endcase

      rsp0_valid <= pop && !pop_tag;
      rsp1_valid <= pop && pop_tag;
      if (pop && !pop_tag) rsp0_rdata <= rx_data;
      if (pop && pop_tag)  rsp1_rdata <= rx_data;
      if (orphan) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Testbench for spi_txn_arbiter: directed scenarios plus a randomized run
// checked against a queue-based behavioural model of the arbiter.
module tb_spi_txn_arbiter;

  logic        SCLK = 1'b0;
  logic        SRESET = 1'b1;
  logic        req0_valid, req0_wr, req0_cs, req0_ready, rsp0_valid;
  logic [6:0]  req0_addr;
  logic [31:0] req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_wr, req1_cs, req1_ready, rsp1_valid;
  logic [6:0]  req1_addr;
  logic [31:0] req1_wdata, rsp1_rdata;
  logic        tx_wr_en, tx_full, rx_rd_en, rx_empty, err_orphan;
  logic [40:0] tx_data;
  logic [31:0] rx_data = 32'h0;
  logic [2:0]  rd_outstanding;
  logic [114:0] outs;

  int errors = 0;
  int checks = 0;

  // RX FIFO stand-in: words pushed by the tests, popped on rx_rd_en.
  logic [31:0] rx_mem [0:255];
  int rx_wr_i = 0;
  int rx_rd_i = 0;
  assign rx_empty = (rx_wr_i == rx_rd_i);
  always @(posedge SCLK) begin
    if (rx_rd_en) begin
      rx_data <= rx_mem[rx_rd_i[7:0]];
      rx_rd_i <= rx_rd_i + 1;
    end
  end

  assign outs = {tx_wr_en, tx_data, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                 rsp0_rdata, rsp1_rdata, rx_rd_en, rd_outstanding, err_orphan};

  always #5 SCLK = ~SCLK;

  spi_txn_arbiter #(.TAG_DEPTH(4), .TAG_AW(2)) dut (
    .SCLK(SCLK), .SRESET(SRESET),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_cs(req0_cs),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_cs(req1_cs),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .tx_wr_en(tx_wr_en), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd_en(rx_rd_en), .rx_data(rx_data), .rx_empty(rx_empty),
    .rd_outstanding(rd_outstanding), .err_orphan(err_orphan)
  );

  function automatic logic [40:0] mk_frame(input logic wr, input logic cs,
                                           input logic [6:0] a, input logic [31:0] d);
    return {wr, cs, a, (wr ? d : 32'h0)};
  endfunction

  task automatic set_req(input int p, input logic v, input logic wr, input logic cs,
                         input logic [6:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_valid = v; req0_wr = wr; req0_cs = cs; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_wr = wr; req1_cs = cs; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic tick;
    @(posedge SCLK);
    #1;
  endtask

  task automatic idle;
    set_req(0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
    tx_full = 1'b0;
  endtask

  task automatic do_reset;
    idle;
    SRESET = 1'b1;
    tick;
    tick;
    SRESET = 1'b0;
    tick;
  endtask

  task automatic rx_push(input logic [31:0] w);
    rx_mem[rx_wr_i[7:0]] = w;
    rx_wr_i = rx_wr_i + 1;
  endtask

  task automatic test_reset;
    idle;
    SRESET = 1'b1;
    set_req(0, 1'b1, 1'b1, 1'b0, 7'h12, 32'h1234);
    tick;
    tick;
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    SRESET = 1'b0;
    idle;
    tick;
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL post_reset_idle: got %h expected 0", outs);
    end
  endtask

  task automatic test_single_write;
    do_reset;
    set_req(0, 1'b1, 1'b1, 1'b0, 7'h12, 32'hDEADBEEF);
    tick;
    checks++;
    if (tx_wr_en !== 1'b1 || tx_data !== 41'h1_12_DEADBEEF || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_write: wr_en=%b data=%h rdy0=%b rdy1=%b expected 1 %h 1 0",
               tx_wr_en, tx_data, req0_ready, req1_ready, 41'h1_12_DEADBEEF);
    end
    set_req(0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
    tick;
    checks++;
    if (tx_wr_en !== 1'b0 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL single_write_end: wr_en=%b rdy0=%b expected 0 0", tx_wr_en, req0_ready);
    end
  endtask

  task automatic test_round_robin;
    logic [6:0]  a [2];
    logic [31:0] d [2];
    logic        c [2];
    int          ep;
    do_reset;
    for (int p = 0; p < 2; p++) begin
      a[p] = 7'($urandom); c[p] = 1'($urandom); d[p] = $urandom;
      set_req(p, 1'b1, 1'b1, c[p], a[p], d[p]);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      ep = k % 2;
      checks++;
      if (tx_wr_en !== 1'b1 || req0_ready !== (ep == 0) || req1_ready !== (ep == 1) ||
          tx_data !== mk_frame(1'b1, c[ep], a[ep], d[ep])) begin
        errors++;
        $display("FAIL rr_grant%0d: wr_en=%b rdy=%b%b data=%h expected port %0d data %h",
                 k, tx_wr_en, req1_ready, req0_ready, tx_data, ep, mk_frame(1'b1, c[ep], a[ep], d[ep]));
      end
      a[ep] = 7'($urandom); c[ep] = 1'($urandom); d[ep] = $urandom;
      set_req(ep, 1'b1, 1'b1, c[ep], a[ep], d[ep]);
    end
    idle;
    tick;
    checks++;
    if (tx_wr_en !== 1'b0) begin
      errors++; $display("FAIL rr_stop: wr_en=%b expected 0", tx_wr_en);
    end
  endtask

  task automatic test_tx_full;
    do_reset;
    tx_full = 1'b1;
    set_req(1, 1'b1, 1'b1, 1'b1, 7'h3A, 32'hCAFEF00D);
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++;
      if (tx_wr_en !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL tx_full_block%0d: wr_en=%b rdy1=%b expected 0 0", k, tx_wr_en, req1_ready);
      end
    end
    tx_full = 1'b0;
    tick;
    checks++;
    if (tx_wr_en !== 1'b1 || req1_ready !== 1'b1 || tx_data !== mk_frame(1'b1, 1'b1, 7'h3A, 32'hCAFEF00D)) begin
      errors++;
      $display("FAIL tx_full_release: wr_en=%b rdy1=%b data=%h expected 1 1 %h",
               tx_wr_en, req1_ready, tx_data, mk_frame(1'b1, 1'b1, 7'h3A, 32'hCAFEF00D));
    end
    idle;
    tick;
  endtask

  task automatic test_read_order;
    int n = 0;
    do_reset;
    set_req(1, 1'b1, 1'b0, 1'b1, 7'h05, 32'hFFFFFFFF);
    tick;
    checks++;
    if (req1_ready !== 1'b1 || tx_data !== mk_frame(1'b0, 1'b1, 7'h05, 32'h0) || rd_outstanding !== 3'd1) begin
      errors++;
      $display("FAIL read1_issue: rdy1=%b data=%h outst=%0d expected 1 %h 1",
               req1_ready, tx_data, rd_outstanding, mk_frame(1'b0, 1'b1, 7'h05, 32'h0));
    end
    set_req(1, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
    set_req(0, 1'b1, 1'b0, 1'b0, 7'h06, 32'h12345678);
    tick;
    checks++;
    if (req0_ready !== 1'b1 || rd_outstanding !== 3'd2) begin
      errors++; $display("FAIL read0_issue: rdy0=%b outst=%0d expected 1 2", req0_ready, rd_outstanding);
    end
    idle;
    rx_push(32'hAAAA5555);
    rx_push(32'h0F0F0F0F);
    for (int c = 0; c < 20; c++) begin
      tick;
      if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
        n++;
        checks++;
        if (n == 1 && (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_rdata !== 32'hAAAA5555 || rd_outstanding !== 3'd1)) begin
          errors++;
          $display("FAIL read_rsp1: v=%b%b data=%h outst=%0d expected port1 AAAA5555 1",
                   rsp1_valid, rsp0_valid, rsp1_rdata, rd_outstanding);
        end
        if (n == 2 && (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp0_rdata !== 32'h0F0F0F0F || rd_outstanding !== 3'd0)) begin
          errors++;
          $display("FAIL read_rsp2: v=%b%b data=%h outst=%0d expected port0 0F0F0F0F 0",
                   rsp1_valid, rsp0_valid, rsp0_rdata, rd_outstanding);
        end
        if (n > 2) begin
          errors++; $display("FAIL read_rsp_extra: got %0d responses expected 2", n);
        end
      end
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL read_rsp_count: got %0d expected 2", n);
    end
  endtask

  task automatic test_tag_full;
    int rsp_c = 0;
    int rdy_c = 0;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, 1'b0, 1'b0, 7'(i), 32'h0);
      tick;
      checks++;
      if (req0_ready !== 1'b1) begin
        errors++; $display("FAIL tag_fill%0d: rdy0=%b expected 1", i, req0_ready);
      end
      set_req(0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
      tick;
    end
    checks++;
    if (rd_outstanding !== 3'd4) begin
      errors++; $display("FAIL tag_count_full: got %0d expected 4", rd_outstanding);
    end
    set_req(0, 1'b1, 1'b0, 1'b1, 7'h44, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (req0_ready !== 1'b0 || tx_wr_en !== 1'b0) begin
        errors++; $display("FAIL tag_full_block%0d: rdy0=%b wr_en=%b expected 0 0", k, req0_ready, tx_wr_en);
      end
    end
    set_req(1, 1'b1, 1'b1, 1'b0, 7'h10, 32'h55AA55AA);
    tick;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || tx_data !== mk_frame(1'b1, 1'b0, 7'h10, 32'h55AA55AA)) begin
      errors++;
      $display("FAIL tag_full_write: rdy=%b%b data=%h expected 10 %h",
               req1_ready, req0_ready, tx_data, mk_frame(1'b1, 1'b0, 7'h10, 32'h55AA55AA));
    end
    set_req(1, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
    rx_push(32'h13572468);
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (rsp0_valid === 1'b1) begin
        rsp_c = c;
        checks++;
        if (rsp0_rdata !== 32'h13572468) begin
          errors++; $display("FAIL tag_full_rsp: got %h expected 13572468", rsp0_rdata);
        end
      end
      if (req0_ready === 1'b1) begin
        rdy_c = c;
        set_req(0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
      end
    end
    checks++;
    if (rsp_c == 0 || rdy_c != rsp_c + 1) begin
      errors++; $display("FAIL tag_full_regrant: ready cycle %0d rsp cycle %0d expected ready one after rsp", rdy_c, rsp_c);
    end
    checks++;
    if (rd_outstanding !== 3'd4) begin
      errors++; $display("FAIL tag_full_after: got %0d expected 4", rd_outstanding);
    end
  endtask

  task automatic test_orphan_reset;
    bit seen = 1'b0;
    bit bad_rsp = 1'b0;
    do_reset;
    rx_push(32'hBAD0BAD0);
    #1;
    checks++;
    if (rx_rd_en !== 1'b1) begin
      errors++; $display("FAIL orphan_rd_en: got %b expected 1", rx_rd_en);
    end
    tick;
    checks++;
    if (rx_rd_en !== 1'b0) begin
      errors++; $display("FAIL orphan_rd_en_cap: got %b expected 0", rx_rd_en);
    end
    tick;
    checks++;
    if (err_orphan !== 1'b1 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL orphan_flag: err=%b rsp=%b%b expected 1 00", err_orphan, rsp1_valid, rsp0_valid);
    end
    repeat (3) tick;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++; $display("FAIL orphan_sticky: got %b expected 1", err_orphan);
    end
    set_req(0, 1'b1, 1'b0, 1'b0, 7'h21, 32'h0);
    tick;
    set_req(0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
    checks++;
    if (rd_outstanding !== 3'd1) begin
      errors++; $display("FAIL midread_issue: got %0d expected 1", rd_outstanding);
    end
    rx_push(32'h600D600D);
    tick;
    SRESET = 1'b1;
    #1;
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL midread_reset: got %h expected 0", outs);
    end
    tick;
    tick;
    SRESET = 1'b0;
    repeat (3) begin
      tick;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) bad_rsp = 1'b1;
    end
    checks++;
    if (err_orphan !== 1'b0 || rd_outstanding !== 3'd0 || bad_rsp) begin
      errors++; $display("FAIL after_reset: err=%b outst=%0d stray_rsp=%b expected 0 0 0", err_orphan, rd_outstanding, bad_rsp);
    end
    rx_push(32'h0BAD0BAD);
    for (int c = 0; c < 6; c++) begin
      tick;
      if (err_orphan === 1'b1) seen = 1'b1;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) bad_rsp = 1'b1;
    end
    checks++;
    if (!seen || bad_rsp) begin
      errors++; $display("FAIL lost_tag_orphan: err_seen=%b stray_rsp=%b expected 1 0", seen, bad_rsp);
    end
  endtask

  // Randomized traffic. The model tracks outstanding reads as a queue of port
  // numbers, the round-robin preference, the port accepted last cycle and
  // whether an RX word is being delivered this cycle.
  task automatic test_random;
    int          tagq [$];
    logic [31:0] mwords [$];
    int          rr_pref = 0;
    int          last_win = -1;
    bit          capt = 1'b0;
    bit          sticky = 1'b0;
    int          reads_issued = 0;
    int          words_pushed = 0;
    bit          hold [2];
    logic        hwr [2];
    logic        hcs [2];
    logic [6:0]  ha [2];
    logic [31:0] hd [2];
    bit          elig [2];
    bit          e_rsp [2];
    logic [31:0] e_data, w;
    logic [40:0] e_frame;
    bit          exp_rd;
    int          win, t;
    do_reset;
    hold[0] = 1'b0; hold[1] = 1'b0;
    e_frame = '0;
    e_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hold[p] && $urandom_range(0, 2) != 0) begin
          hold[p] = 1'b1;
          hwr[p] = 1'($urandom_range(0, 1));
          hcs[p] = 1'($urandom);
          ha[p] = 7'($urandom);
          hd[p] = $urandom;
        end
        if (hold[p]) set_req(p, 1'b1, hwr[p], hcs[p], ha[p], hd[p]);
        else         set_req(p, 1'b0, 1'($urandom), 1'($urandom), 7'($urandom), $urandom);
      end
      tx_full = ($urandom_range(0, 3) == 0);
      if (words_pushed < reads_issued && $urandom_range(0, 1) == 1) begin
        w = $urandom;
        rx_push(w);
        mwords.push_back(w);
        words_pushed++;
      end
      #1;
      exp_rd = !capt && (rx_wr_i != rx_rd_i);
      checks++;
      if (rx_rd_en !== exp_rd) begin
        errors++; $display("FAIL rand_rd_en cyc%0d: got %b expected %b", cyc, rx_rd_en, exp_rd);
      end

      for (int p = 0; p < 2; p++)
        elig[p] = hold[p] && (last_win != p) && (hwr[p] || tagq.size() < 4);
      win = -1;
      if (!tx_full) begin
        if (elig[0] && elig[1]) win = rr_pref;
        else if (elig[0])       win = 0;
        else if (elig[1])       win = 1;
      end
      e_rsp[0] = 1'b0; e_rsp[1] = 1'b0;
      if (capt) begin
        capt = 1'b0;
        w = mwords.pop_front();
        if (tagq.size() > 0) begin
          t = tagq.pop_front();
          e_rsp[t] = 1'b1;
          e_data = w;
        end else begin
          sticky = 1'b1;
        end
      end else if (exp_rd) begin
        capt = 1'b1;
      end
      if (win >= 0) begin
        e_frame = mk_frame(hwr[win], hcs[win], ha[win], hd[win]);
        rr_pref = 1 - win;
        if (!hwr[win]) begin
          tagq.push_back(win);
          reads_issued++;
        end
        hold[win] = 1'b0;
      end
      last_win = win;

      tick;
      checks++;
      if (tx_wr_en !== (win >= 0) || req0_ready !== (win == 0) || req1_ready !== (win == 1) ||
          (win >= 0 && tx_data !== e_frame)) begin
        errors++;
        $display("FAIL rand_grant cyc%0d: wr_en=%b rdy=%b%b data=%h expected winner %0d data %h",
                 cyc, tx_wr_en, req1_ready, req0_ready, tx_data, win, e_frame);
      end
      checks++;
      if (rsp0_valid !== e_rsp[0] || rsp1_valid !== e_rsp[1] ||
          (e_rsp[0] && rsp0_rdata !== e_data) || (e_rsp[1] && rsp1_rdata !== e_data)) begin
        errors++;
        $display("FAIL rand_rsp cyc%0d: v=%b%b d0=%h d1=%h expected v=%b%b data %h",
                 cyc, rsp1_valid, rsp0_valid, rsp0_rdata, rsp1_rdata, e_rsp[1], e_rsp[0], e_data);
      end
      checks++;
      if (rd_outstanding !== 3'(tagq.size()) || err_orphan !== sticky) begin
        errors++;
        $display("FAIL rand_count cyc%0d: outst=%0d err=%b expected %0d %b",
                 cyc, rd_outstanding, err_orphan, tagq.size(), sticky);
      end
    end
    idle;
    tick;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle;
    test_reset;
    test_single_write;
    test_round_robin;
    test_tx_full;
    test_read_order;
    test_tag_full;
    test_orphan_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
